request_encoder32to5: RTL and testbench

- Sequential encoder: the inverse of the 1-to-32 one-hot address decoder. It collects up to 32 one-hot request lines and returns them as a stream of 5-bit indices.
- Request bits are latched into a pending register.
- One pending bit is selected per grant and presented on a valid/ready handshake.
- The bit is cleared when the consumer accepts it.
- Used by the Lab 3 CPU side to turn asserted per-register or per-line strobes back into addresses, for example to drive a register-file write port from a collected mask.

---
 rtl/request_encoder32to5.sv | 94 +++++++++
 tb/tb_request_encoder32to5.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/request_encoder32to5.sv
// Sequential 32-to-5 request encoder: latches one-hot request lines into a pending mask and
// streams their indices over a valid/ready handshake. Define REQUEST_ENCODER_ROUND_ROBIN_EN for round-robin selection.
module request_encoder32to5 #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             req_valid,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_index,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clear_mask;
    logic [IDXW-1:0]  sel;

    assign set_mask   = req_valid ? req_in : '0;
    assign clear_mask = (out_valid && out_ready) ? (WIDTH'(1) << out_index) : '0;
    assign busy       = (|pending) || out_valid;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    logic [IDXW-1:0] last;
    logic [IDXW-1:0] cand;

    // Scan from last+1 upward with wrap; iterating downward lets the nearest candidate win.
    always_comb begin
        sel  = '0;
        cand = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cand = last + IDXW'(1) + IDXW'(i);
            if (pending[cand]) sel = cand;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last <= IDXW'(WIDTH - 1);
        end else if (out_valid && out_ready) begin
            last <= out_index;
        end
    end
`else
    // Fixed priority: the lowest set index wins.
    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) sel = IDXW'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            overrun   <= 1'b0;
        end else begin
            // Set wins over clear, so a re-request of the accepted bit stays pending.
            pending <= (pending & ~clear_mask) | set_mask;
            overrun <= |(set_mask & pending & ~clear_mask);
            case (state)
                IDLE: begin
                    if (|pending) begin
                        out_index <= sel;
                        out_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_request_encoder32to5.sv
// Directed bench for request_encoder32to5; expectations for the round-robin case follow
// REQUEST_ENCODER_ROUND_ROBIN_EN so the same file checks either build.
module tb_request_encoder32to5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] req_in;
    logic        req_valid;
    logic        out_valid;
    logic [4:0]  out_index;
    logic        out_ready;
    logic [31:0] pending;
    logic        overrun;
    logic        busy;

    int checks = 0;
    int errors = 0;

    request_encoder32to5 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_in    (req_in),
        .req_valid (req_valid),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_ready (out_ready),
        .pending   (pending),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [4:0] grants [4];
    logic [4:0] rr_exp [4];
    int         ngrant;

    initial begin
        reset_n = 1'b0; req_in = '0; req_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_pending", pending, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // single request, two-cycle latency
        reset_n = 1'b1; out_ready = 1'b1; req_in = 32'h0000_0010; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        chk("single_pend", pending, 32'h10);
        chk("single_valid_early", 32'(out_valid), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_index", 32'(out_index), 32'd4);
        tick();
        chk("single_done_pend", pending, 32'h0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // multi-bit drain: 0, 2, 31 separated by IDLE cycles
        req_in = 32'h8000_0005; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); chk("drain_idx0", 32'(out_index), 32'd0); chk("drain_v0", 32'(out_valid), 32'd1);
        tick(); chk("drain_gap0", 32'(out_valid), 32'd0);
        tick(); chk("drain_idx2", 32'(out_index), 32'd2); chk("drain_v2", 32'(out_valid), 32'd1);
        tick(); chk("drain_gap1", 32'(out_valid), 32'd0);
        tick(); chk("drain_idx31", 32'(out_index), 32'h1f);
        tick(); chk("drain_empty", pending, 32'h0); chk("drain_busy", 32'(busy), 32'd0);

        // backpressure with a lower-index arrival during the stall
        out_ready = 1'b0; req_in = 32'h8; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); chk("bp_idx", 32'(out_index), 32'd3);
        for (int i = 0; i < 5; i++) begin
            req_in = 32'h1; req_valid = (i == 1);
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_idx", 32'(out_index), 32'd3);
        end
        req_valid = 1'b0; out_ready = 1'b1;
        tick(); chk("bp_accept_pend", pending, 32'h1); chk("bp_accept_valid", 32'(out_valid), 32'd0);
        tick(); chk("bp_next_idx", 32'(out_index), 32'd0); chk("bp_next_valid", 32'(out_valid), 32'd1);
        tick(); chk("bp_empty", pending, 32'h0);

        // set/clear collision on bit 7 and overrun
        out_ready = 1'b0; req_in = 32'h80; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); chk("col_idx", 32'(out_index), 32'd7);
        out_ready = 1'b1; req_valid = 1'b1;
        tick();
        chk("col_pend", pending, 32'h80);
        chk("col_no_overrun", 32'(overrun), 32'd0);
        out_ready = 1'b0; req_valid = 1'b0;
        tick(); chk("col_regrant", 32'(out_index), 32'd7);
        req_valid = 1'b1;
        tick(); chk("ovr_pulse", 32'(overrun), 32'd1);
        req_valid = 1'b0;
        tick(); chk("ovr_clear", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        tick(); chk("col_empty", pending, 32'h0);

        // reset mid-operation with pending all ones and a grant on index 1
        out_ready = 1'b0; req_in = 32'hFFFF_FFFE; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); req_in = 32'h1; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        chk("mid_pend", pending, 32'hFFFF_FFFF);
        chk("mid_idx", 32'(out_index), 32'd1);
        reset_n = 1'b0;
        tick(); reset_n = 1'b1;
        chk("mid_rst_pend", pending, 32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_idx", 32'(out_index), 32'd0);

        // zero request is a no-op
        req_in = 32'h0; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        chk("zero_pend", pending, 32'h0);
        chk("zero_busy", 32'(busy), 32'd0);

        // all ones drain in 32 grants (default build: 0..31)
`ifndef REQUEST_ENCODER_ROUND_ROBIN_EN
        out_ready = 1'b1; req_in = 32'hFFFF_FFFF; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("all_idx", 32'(out_index), 32'(i));
            tick();
        end
        chk("all_empty", pending, 32'h0);
        chk("all_busy", 32'(busy), 32'd0);
`endif

        // starvation check: bit 0 re-requested every cycle, bit 5 once
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        rr_exp[0] = 5'd0; rr_exp[1] = 5'd5; rr_exp[2] = 5'd0; rr_exp[3] = 5'd0;
`else
        rr_exp[0] = 5'd0; rr_exp[1] = 5'd0; rr_exp[2] = 5'd0; rr_exp[3] = 5'd0;
`endif
        ngrant = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_in = (c == 0) ? 32'h21 : 32'h1; req_valid = 1'b1;
            tick();
            if (out_valid && ngrant < 4) begin
                grants[ngrant] = out_index;
                ngrant++;
            end
        end
        req_valid = 1'b0;
        chk("rr_count", 32'(ngrant), 32'd4);
        for (int g = 0; g < 4; g++) begin
            chk("rr_order", 32'(grants[g]), 32'(rr_exp[g]));
        end
        for (int c = 0; c < 8; c++) tick();
        chk("rr_final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
